first_filter_table_loader: RTL

Sequences runtime writes into the first-filter match tables (8 dual-port 8192x64 tables sharing one wr_data/wr_addr/wr_en bus) while packet traffic is live. Accepts host commands (single-entry write or range fill), holds the ingress stream at a packet boundary, waits for the filter pipeline to drain, and issues one table write per cycle. It then releases the stream and reports completion. It sits between the ingress stream and first_filter, and drives the filter's table write port.

---
 rtl/first_filter_table_loader_if.sv | 35 +++
 rtl/first_filter_table_loader.sv | 108 ++++++++++
 2 files changed

// File: rtl/first_filter_table_loader_if.sv
// first_filter_table_loader_if: host command, ingress stream and table write port bundle
interface first_filter_table_loader_if #(
    parameter int AWIDTH = 13,
    parameter int DWIDTH = 64,
    parameter int LWIDTH = 14
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [AWIDTH-1:0] cmd_addr;
    logic [LWIDTH-1:0] cmd_len;
    logic [DWIDTH-1:0] cmd_data;
    logic              up_valid;
    logic              up_sop;
    logic              up_eop;
    logic              up_ready;
    logic              filt_valid;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       wr_count;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, up_valid, up_sop, up_eop,
        input  cmd_ready, up_ready, filt_valid, wr_en, wr_addr, wr_data, busy, done, err, wr_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, up_valid, up_sop, up_eop,
        output cmd_ready, up_ready, filt_valid, wr_en, wr_addr, wr_data, busy, done, err, wr_count
    );
endinterface

// File: rtl/first_filter_table_loader.sv
// first_filter_table_loader: pauses ingress at a packet boundary, drains the filter, then writes the match tables
module first_filter_table_loader #(
    parameter int AWIDTH       = 13,
    parameter int DWIDTH       = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int LWIDTH       = 14
) (
    input logic                        clk,
    input logic                        rst_n,
    first_filter_table_loader_if.slave bus
);
    localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_BND, DRAIN, WRITE, DONE} state_t;

    state_t            state;
    logic              in_pkt;
    logic [LWIDTH-1:0] left;
    logic [CW-1:0]     cnt;
    logic              up_ready;
    logic              beat;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       wr_count;

    assign up_ready       = state == IDLE || state == DONE || (state == WAIT_BND && in_pkt);
    assign beat           = bus.up_valid && up_ready;
    assign bus.up_ready   = up_ready;
    assign bus.filt_valid = beat;
    assign bus.cmd_ready  = state == IDLE;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.wr_count   = wr_count;

    // Track whether the stream is between a multi-beat sop and its eop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            in_pkt <= 1'b0;
        else if (beat)
            in_pkt <= bus.up_eop ? 1'b0 : (bus.up_sop || in_pkt);
    end

    // Command sequencer: the latched command lives in wr_addr/wr_data/left until the write burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_count <= '0;
            left     <= '0;
            cnt      <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            wr_count <= wr_count + 32'(wr_en);
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    if (bus.cmd_op[1]) begin
                        err <= 1'b1;
                    end else begin
                        state   <= WAIT_BND;
                        busy    <= 1'b1;
                        wr_addr <= bus.cmd_addr;
                        wr_data <= bus.cmd_data;
                        left    <= bus.cmd_op[0] ? bus.cmd_len : LWIDTH'(1);
                    end
                end
                WAIT_BND: if (!in_pkt || (beat && bus.up_eop)) begin
                    state <= DRAIN;
                    cnt   <= CW'(DRAIN_CYCLES - 1);
                end
                DRAIN: if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else if (left == '0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= WRITE;
                    wr_en <= 1'b1;
                end
                WRITE: if (left == LWIDTH'(1)) begin
                    state <= DONE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    left    <= left - LWIDTH'(1);
                    wr_addr <= wr_addr + AWIDTH'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
